// File: rtl/ssp_uart_bus_arb.sv
// Two-requester round-robin arbiter in front of the ssp_uart register port.
// Each access holds SSP_SSEL for ACC_CYC cycles, then one recovery cycle signals done.
module ssp_uart_bus_arb #(
  parameter int ACC_CYC = 2,
  parameter int DW      = 12
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          m0_req,
  input  logic          m0_wnr,
  input  logic [2:0]    m0_ra,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic          m1_wnr,
  input  logic [2:0]    m1_ra,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rd,
  output logic          SSP_SSEL,
  output logic [2:0]    SSP_RA,
  output logic          SSP_WnR,
  output logic [DW-1:0] SSP_DI,
  input  logic [DW-1:0] SSP_DO,
  output logic          busy
);

  generate
    if (ACC_CYC < 1 || ACC_CYC > 15) begin : g_bad_acc_cyc
      $error("ssp_uart_bus_arb: ACC_CYC must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOV} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic          rdy_q;
  logic          take;
  logic [2:0]    ra_q;
  logic          wnr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rd0_q, rd1_q;
  logic          sel;
  logic          cap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        // rdy_q keeps the first edge after reset release from arbitrating
        if (rdy_q && (m0_req || m1_req)) begin
          take    = 1'b1;
          win_d   = (m0_req && m1_req) ? ~last_q : m1_req;
          last_d  = win_d;
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = RECOV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cap = (state_q == ACCESS) && (cnt_q == CNT_LAST) && !wnr_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      rdy_q   <= 1'b1;
      if (cap && !win_q) rd0_q <= SSP_DO;
      if (cap && win_q)  rd1_q <= SSP_DO;
    end
  end

  // Latched access fields need no reset: they only reach the port while SSEL is high
  always_ff @(posedge Clk) begin
    if (take) begin
      ra_q  <= win_d ? m1_ra  : m0_ra;
      wnr_q <= win_d ? m1_wnr : m0_wnr;
      wd_q  <= win_d ? m1_wd  : m0_wd;
    end
  end

  assign sel      = (state_q == ACCESS);
  assign SSP_SSEL = sel;
  assign SSP_RA   = sel ? ra_q  : 3'd0;
  assign SSP_WnR  = sel ? wnr_q : 1'b0;
  assign SSP_DI   = sel ? wd_q  : '0;

  assign m0_gnt  = sel && (cnt_q == 4'd0) && !win_q;
  assign m1_gnt  = sel && (cnt_q == 4'd0) &&  win_q;
  assign m0_done = (state_q == RECOV) && !win_q;
  assign m1_done = (state_q == RECOV) &&  win_q;
  assign m0_rd   = rd0_q;
  assign m1_rd   = rd1_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ssp_uart_bus_arb.sv
// Scoreboard bench for ssp_uart_bus_arb: a timeline model predicts each access,
// a negedge monitor compares the DUT against the queued predictions.
module tb_ssp_uart_bus_arb;
  localparam int ACC = 2;
  localparam int DW  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 0, m0_wnr = 0, m1_req = 0, m1_wnr = 0;
  logic [2:0] m0_ra = 0, m1_ra = 0;
  logic [DW-1:0] m0_wd = 0, m1_wd = 0, ssp_do = 0;
  logic m0_gnt, m0_done, m1_gnt, m1_done, ssel, wnr_o, busy;
  logic [DW-1:0] m0_rd, m1_rd, di_o;
  logic [2:0] ra_o;

  always #5 clk = ~clk;

  ssp_uart_bus_arb #(.ACC_CYC(ACC), .DW(DW)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .m0_req(m0_req), .m0_wnr(m0_wnr), .m0_ra(m0_ra), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_wnr(m1_wnr), .m1_ra(m1_ra), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rd(m1_rd),
    .SSP_SSEL(ssel), .SSP_RA(ra_o), .SSP_WnR(wnr_o), .SSP_DI(di_o),
    .SSP_DO(ssp_do), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: access timeline ----------------
  typedef struct {
    int who;
    bit wnr;
    logic [2:0] ra;
    logic [DW-1:0] wd;
    int e;
  } acc_t;

  acc_t q[$];
  logic [DW-1:0] mrd [2];
  int cyc = 0;
  int rel = 0;
  int next_free = 0;
  int lastw = 1;

  initial begin
    mrd[0] = '0;
    mrd[1] = '0;
  end

  always @(negedge rst_n) begin
    q.delete();
    mrd[0] = '0;
    mrd[1] = '0;
    next_free = 0;
    lastw = 1;
  end

  always @(posedge clk) begin
    acc_t a;
    cyc++;
    if (rst_n !== 1'b1) begin
      rel = 0;
    end else begin
      rel++;
      if (q.size() > 0 && cyc == q[0].e + ACC && !q[0].wnr) mrd[q[0].who] = ssp_do;
      // arbitration needs one settled edge after reset and a free bus
      if (rel >= 2 && cyc >= next_free && (m0_req || m1_req)) begin
        if (m0_req && m1_req) a.who = (lastw == 1) ? 0 : 1;
        else                  a.who = m1_req ? 1 : 0;
        lastw = a.who;
        a.wnr = a.who ? m1_wnr : m0_wnr;
        a.ra  = a.who ? m1_ra  : m0_ra;
        a.wd  = a.who ? m1_wd  : m0_wd;
        a.e   = cyc;
        q.push_back(a);
        next_free = cyc + ACC + 2;
      end
    end
  end

  // ---------------- monitor ----------------
  int glog[$];
  int gcyc[$];
  int gcnt [2] = '{0, 0};
  int dcnt [2] = '{0, 0};

  always @(negedge clk) begin
    bit has, es;
    int e;
    logic [1:0] eg, ed;
    if (rst_n === 1'b1) begin
      has = (q.size() > 0);
      e = 0; es = 0; eg = 2'b00; ed = 2'b00;
      if (has) begin
        e  = q[0].e;
        es = (cyc >= e) && (cyc < e + ACC);
        if (cyc == e)       eg = q[0].who ? 2'b10 : 2'b01;
        if (cyc == e + ACC) ed = q[0].who ? 2'b10 : 2'b01;
      end
      chk("ssel", 32'(ssel), 32'(es));
      chk("busy", 32'(busy), 32'(has));
      if (es) chk("ssp_bus", 32'({ra_o, wnr_o, di_o}), 32'({q[0].ra, q[0].wnr, q[0].wd}));
      else    chk("ssp_bus_idle", 32'({ra_o, wnr_o, di_o}), 32'd0);
      chk("gnt", 32'({m1_gnt, m0_gnt}), 32'(eg));
      chk("done", 32'({m1_done, m0_done}), 32'(ed));
      chk("m0_rd", 32'(m0_rd), 32'(mrd[0]));
      chk("m1_rd", 32'(m1_rd), 32'(mrd[1]));
      if (m0_gnt) begin glog.push_back(0); gcyc.push_back(cyc); gcnt[0]++; end
      if (m1_gnt) begin glog.push_back(1); gcyc.push_back(cyc); gcnt[1]++; end
      if (m0_done) dcnt[0]++;
      if (m1_done) dcnt[1]++;
      if (ed != 2'b00) void'(q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  int want [2] = '{0, 0};
  bit do_fix = 0;
  logic [DW-1:0] do_val = '0;

  always @(negedge clk) begin
    #1;
    ssp_do = do_fix ? do_val : DW'($urandom);
    if (m0_gnt && want[0] > 0) begin want[0]--; if (want[0] == 0) m0_req = 0; end
    if (m1_gnt && want[1] > 0) begin want[1]--; if (want[1] == 0) m1_req = 0; end
  end

  task automatic set_req(input int n, input int times, input bit w,
                         input logic [2:0] ra, input logic [DW-1:0] wd);
    want[n] = times;
    if (n == 0) begin m0_wnr = w; m0_ra = ra; m0_wd = wd; m0_req = 1; end
    else        begin m1_wnr = w; m1_ra = ra; m1_wd = wd; m1_req = 1; end
  endtask

  task automatic raise(input int n, input int times, input bit w,
                       input logic [2:0] ra, input logic [DW-1:0] wd);
    @(negedge clk); #2;
    set_req(n, times, w, ra, wd);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((want[0] != 0 || want[1] != 0 || busy) && i < budget) begin
      @(negedge clk); i++;
    end
    if (i >= budget) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 0;
    want[0] = 0; want[1] = 0; m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'({m0_gnt, m0_done, m1_gnt, m1_done, ssel, ra_o, wnr_o, busy}), 32'd0);
    chk("rst_data", 32'({m0_rd, m1_rd, di_o}), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    rst_n = 1;
  endtask

  initial begin
    int g0, d0, n0;
    bit pulse [2];
    pulse[0] = 0; pulse[1] = 0;

    do_reset();
    release_reset();

    // write from m0
    raise(0, 1, 1'b1, 3'd3, 12'h0A5);
    wait_idle(40);
    chk("wr_m0_rd_kept", 32'(m0_rd), 32'd0);

    // read from m1 with a fixed SSP_DO
    do_fix = 1; do_val = 12'h3C1;
    raise(1, 1, 1'b0, 3'd5, 12'h000);
    wait_idle(40);
    do_fix = 0;
    chk("rd_m1_value", 32'(m1_rd), 32'h3C1);
    chk("rd_m0_kept", 32'(m0_rd), 32'd0);

    // back-to-back: m0 keeps req high for three accesses
    g0 = gcnt[0]; d0 = dcnt[0];
    raise(0, 3, 1'b1, 3'd1, 12'h5A5);
    wait_idle(60);
    chk("b2b_gnts", 32'(gcnt[0] - g0), 32'd3);
    chk("b2b_dones", 32'(dcnt[0] - d0), 32'd3);

    // dropped request during a busy period
    n0 = gcnt[1];
    raise(0, 1, 1'b1, 3'd2, 12'h111);
    begin
      int i = 0;
      while (!busy && i < 20) begin @(negedge clk); i++; end
      if (i >= 20) chk("drop_busy_timeout", 32'd1, 32'd0);
    end
    #2; m1_req = 1; m1_ra = 3'd7; m1_wnr = 1'b1;
    @(negedge clk); #2; m1_req = 0;
    wait_idle(40);
    repeat (4) @(negedge clk);
    chk("drop_no_m1_gnt", 32'(gcnt[1] - n0), 32'd0);

    // reset abort during the first SSEL cycle
    raise(0, 1, 1'b0, 3'd4, 12'h000);
    begin
      int i = 0;
      while (!ssel && i < 20) begin @(negedge clk); i++; end
      if (i >= 20) chk("abort_sel_timeout", 32'd1, 32'd0);
    end
    #2; rst_n = 0; want[0] = 0; m0_req = 0;
    #1;
    chk("abort_ssel", 32'(ssel), 32'd0);
    chk("abort_outs", 32'({m0_gnt, m0_done, m1_gnt, m1_done, ra_o, wnr_o, busy}), 32'd0);
    chk("abort_data", 32'({m0_rd, m1_rd, di_o}), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("abort_no_done", 32'({m0_done, m1_done}), 32'd0);

    // simultaneous requests right after reset release: alternation from m0
    glog.delete(); gcyc.delete();
    @(negedge clk); #2;
    set_req(0, 2, 1'b1, 3'd6, 12'hABC);
    set_req(1, 2, 1'b0, 3'd0, 12'h000);
    release_reset();
    wait_idle(80);
    chk("sim_gnt_count", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      chk("sim_order", 32'({glog[0][3:0], glog[1][3:0], glog[2][3:0], glog[3][3:0]}), 32'h0101);
      chk("sim_spacing", 32'(gcyc[1] - gcyc[0]), 32'(ACC + 2));
    end

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #2;
      for (int n = 0; n < 2; n++) begin
        if (pulse[n]) begin
          pulse[n] = 0;
          if (n == 0) m0_req = 0; else m1_req = 0;
        end else if (want[n] == 0 && (n == 0 ? !m0_req : !m1_req)) begin
          if ($urandom_range(0, 4) == 0)
            set_req(n, $urandom_range(1, 3), 1'($urandom), 3'($urandom), DW'($urandom));
          else if (busy && $urandom_range(0, 9) == 0) begin
            pulse[n] = 1;
            if (n == 0) m0_req = 1; else m1_req = 1;
          end
        end
      end
    end
    m0_req = (want[0] != 0); m1_req = (want[1] != 0);
    wait_idle(200);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
